// File: rtl/actor_trigger_sync.sv
// Trigger FSM that launches one HLS actor, retries and sleeps on non-executed
// returns, and joins the network-wide sleep/sync barrier before reporting done.
module actor_trigger_sync #(
   parameter int unsigned MODE         = 0,
   parameter int unsigned RETRY_LIMIT  = 1,
   parameter int unsigned SLEEP_CYCLES = 16,
   parameter int unsigned COUNT_WIDTH  = 32
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic                   ap_start,
   output logic                   ap_done,
   output logic                   ap_idle,
   output logic                   ap_ready,
   output logic                   actor_start,
   input  logic                   actor_done,
   input  logic [1:0]             actor_return,
   input  logic                   all_sleeping,
   input  logic                   all_sync_wait,
   input  logic                   all_sync,
   output logic                   sleep,
   output logic                   sync_wait,
   output logic                   sync_exec,
   output logic [COUNT_WIDTH-1:0] exec_count
);

   localparam logic [1:0] RET_EXECUTED = 2'd3;

   // The timer only has to reach SLEEP_CYCLES-1; it parks there when the
   // timeout is disabled so it can never wrap.
   localparam int unsigned SLEEP_LAST  = (SLEEP_CYCLES == 0) ? 0 : SLEEP_CYCLES - 1;
   localparam int unsigned TIMER_WIDTH = (SLEEP_LAST < 1) ? 1 : $clog2(SLEEP_LAST + 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(SLEEP_LAST);
   localparam logic [8:0] RETRY_MAX = 9'(RETRY_LIMIT);
   localparam bit TIMER_ENABLE = (MODE == 0) && (SLEEP_CYCLES != 0);

   typedef enum logic [2:0] {
      IDLE_STATE,
      LAUNCH_STATE,
      CHECK_STATE,
      SLEEP_STATE,
      SYNC_LAUNCH_STATE,
      SYNC_CHECK_STATE,
      SYNC_WAIT_STATE,
      SYNC_EXEC_STATE
   } state_t;

   state_t                   state_q, state_d;
   logic [7:0]               retry_q, retry_d;
   logic [8:0]               retry_inc;
   logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
   logic [COUNT_WIDTH-1:0]   exec_q, exec_d, exec_sat;
   logic                     done_q, done_d;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE_STATE;
         retry_q <= '0;
         timer_q <= '0;
         exec_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         timer_q <= timer_d;
         exec_q  <= exec_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      timer_d   = timer_q;
      exec_d    = exec_q;
      done_d    = 1'b0;
      retry_inc = {1'b0, retry_q} + 9'd1;
      exec_sat  = (exec_q == {COUNT_WIDTH{1'b1}}) ? exec_q : exec_q + COUNT_WIDTH'(1);

      case (state_q)
         IDLE_STATE: begin
            if (ap_start) begin
               exec_d  = '0;
               retry_d = '0;
               state_d = LAUNCH_STATE;
            end
         end
         LAUNCH_STATE: state_d = CHECK_STATE;
         CHECK_STATE: begin
            if (actor_done) begin
               if (actor_return == RET_EXECUTED) begin
                  exec_d  = exec_sat;
                  retry_d = '0;
                  state_d = LAUNCH_STATE;
               end else begin
                  retry_d = retry_inc[7:0];
                  if (retry_inc >= RETRY_MAX) begin
                     timer_d = '0;
                     state_d = SLEEP_STATE;
                  end else begin
                     state_d = LAUNCH_STATE;
                  end
               end
            end
         end
         SLEEP_STATE: begin
            if (timer_q != TIMER_LAST) timer_d = timer_q + TIMER_WIDTH'(1);
            // The barrier outranks the local timeout when both fire together.
            if (all_sleeping) begin
               state_d = SYNC_LAUNCH_STATE;
            end else if (TIMER_ENABLE && (timer_q == TIMER_LAST)) begin
               retry_d = '0;
               state_d = LAUNCH_STATE;
            end
         end
         SYNC_LAUNCH_STATE: state_d = SYNC_CHECK_STATE;
         SYNC_CHECK_STATE: begin
            if (actor_done) begin
               if (actor_return == RET_EXECUTED) begin
                  exec_d  = exec_sat;
                  state_d = SYNC_EXEC_STATE;
               end else begin
                  state_d = SYNC_WAIT_STATE;
               end
            end
         end
         SYNC_WAIT_STATE: begin
            if (all_sync_wait) begin
               done_d  = 1'b1;
               state_d = IDLE_STATE;
            end else if (all_sync) begin
               retry_d = '0;
               state_d = LAUNCH_STATE;
            end
         end
         SYNC_EXEC_STATE: begin
            if (all_sync) begin
               retry_d = '0;
               state_d = LAUNCH_STATE;
            end
         end
         default: state_d = IDLE_STATE;
      endcase
   end

   assign ap_done     = done_q;
   assign ap_ready    = done_q;
   assign ap_idle     = (state_q == IDLE_STATE);
   assign actor_start = (state_q == LAUNCH_STATE) || (state_q == SYNC_LAUNCH_STATE);
   assign sleep       = (state_q == SLEEP_STATE);
   assign sync_wait   = (state_q == SYNC_WAIT_STATE);
   assign sync_exec   = (state_q == SYNC_EXEC_STATE);
   assign exec_count  = exec_q;

endmodule
